// File: rtl/stream_tx_pkg.sv
// stream_tx_pkg: sequencer states, 8N1 frame constants and bit-period helper for uart_stream_tx.
package stream_tx_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
  function automatic int bit_period(input int clock_hz, input int baud);
    return (clock_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/stream_tx_serializer.sv
// stream_tx_serializer: shifts one start/data/stop frame out, P clocks per bit.
module stream_tx_serializer
  import stream_tx_pkg::*;
#(
  parameter int P = 87
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Load,
  input  logic                 Enable,
  input  logic [DATA_BITS-1:0] Data,
  output logic                 Tx,
  output logic                 BitEnd,
  output logic                 FrameEnd
);
  localparam int BW = $clog2(P);
  localparam int CW = $clog2(FRAME_BITS);
  logic [BW-1:0] baud_cnt;
  logic [CW-1:0] bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  assign BitEnd = Enable && baud_cnt == BW'(P - 1);
  assign FrameEnd = BitEnd && bit_cnt == CW'(FRAME_BITS - 1);
  assign Tx = shift[0];
  // Load wins over counting so the next frame follows the stop bit with no gap.
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '1;
    end else if (Load) begin
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= {{STOP_BITS{1'b1}}, Data, 1'b0};
    end else if (Enable) begin
      baud_cnt <= BitEnd ? '0 : baud_cnt + 1'b1;
      if (BitEnd) begin
        bit_cnt <= bit_cnt + 1'b1;
        shift <= {1'b1, shift[FRAME_BITS-1:1]};
      end
    end else begin
      baud_cnt <= '0;
      bit_cnt <= '0;
    end
endmodule

// File: rtl/uart_stream_tx.sv
// uart_stream_tx: buffered back-to-back 8N1 burst transmitter.
// Define STREAM_TX_LOOP_EN to repeat the burst until Stop_i is seen.
module uart_stream_tx
  import stream_tx_pkg::*;
#(
  parameter int CLOCK_HZ = 10_000_000,
  parameter int BAUD = 115200,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Wr_i,
  input  logic [AW-1:0]        WrAddr_i,
  input  logic [DATA_BITS-1:0] WrData_i,
  input  logic [AW:0]          Length_i,
  input  logic                 Start_i,
`ifdef STREAM_TX_LOOP_EN
  input  logic                 Stop_i,
`endif
  output logic                 Busy_o,
  output logic                 Done_o,
  output logic [AW-1:0]        Pointer_o,
  output logic                 Tx_o
);
  localparam int P = bit_period(CLOCK_HZ, BAUD);
  localparam int DW = $clog2(DATA_BITS);
  state_t state, state_nx;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0] pointer, last_idx, len_last, next_ptr, rd_addr;
  logic [DW-1:0] dcnt;
  logic load, enable, bit_end, frame_end, ser_tx, last, finish, done_q;
  assign last = pointer == last_idx;
  assign next_ptr = last ? '0 : pointer + 1'b1;
  assign len_last = (Length_i == '0 || Length_i > (AW+1)'(DEPTH)) ? AW'(DEPTH - 1) : AW'(Length_i - 1'b1);
  assign Pointer_o = pointer;
  assign Done_o = done_q;
`ifdef STREAM_TX_LOOP_EN
  logic stop_pend;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) stop_pend <= 1'b0;
    else stop_pend <= (state != IDLE) && (stop_pend || Stop_i);
  assign finish = last && (stop_pend || Stop_i);
`else
  assign finish = last;
`endif
  always_ff @(posedge Clock)
    if (Wr_i) mem[WrAddr_i] <= WrData_i;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = Start_i ? LOAD : IDLE;
      LOAD:    state_nx = START;
      START:   state_nx = bit_end ? DATA : START;
      DATA:    state_nx = (bit_end && dcnt == DW'(DATA_BITS - 1)) ? STOP : DATA;
      STOP:    state_nx = frame_end ? (finish ? IDLE : START) : STOP;
      default: state_nx = IDLE;
    endcase
  end
  // During STOP the read address already points at the next byte, so the reload edge prefetches it.
  always_comb begin
    Busy_o = state != IDLE;
    enable = state == START || state == DATA || state == STOP;
    load = state == LOAD || (state == STOP && frame_end && !finish);
    rd_addr = state == STOP ? next_ptr : pointer;
    Tx_o = enable ? ser_tx : 1'b1;
  end
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      pointer <= '0;
      last_idx <= '0;
      dcnt <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= state == STOP && frame_end && finish;
      dcnt <= state == DATA ? dcnt + DW'(bit_end) : '0;
      if (state == IDLE && Start_i) begin
        pointer <= '0;
        last_idx <= len_last;
      end else if (state == STOP && frame_end && !finish) pointer <= next_ptr;
    end
  stream_tx_serializer #(.P(P)) u_ser (
    .Clock    (Clock),
    .Reset    (Reset),
    .Load     (load),
    .Enable   (enable),
    .Data     (mem[rd_addr]),
    .Tx       (ser_tx),
    .BitEnd   (bit_end),
    .FrameEnd (frame_end)
  );
endmodule

// File: tb/tb_uart_stream_tx.sv
// tb_uart_stream_tx: checks uart_stream_tx line waveform, timing and control outputs against a frame-level model.
module tb_uart_stream_tx;
  localparam int P = 10;
  localparam int FR = 10 * P;
  logic Clock, Reset, Wr_i, Start_i, Busy_o, Done_o, Tx_o;
  logic [2:0] WrAddr_i, Pointer_o;
  logic [7:0] WrData_i;
  logic [3:0] Length_i;
`ifdef STREAM_TX_LOOP_EN
  logic Stop_i;
`endif
  logic [7:0] model [8];
  logic [7:0] pat [8];
  int compared, mismatched;
  typedef struct {
    int len; int n; int cyc; bit hold; int wr_j; int wr_a; int wr_d; int pulse_j; int stop_j; int per;
  } vec_t;
  vec_t tbl [$];

  uart_stream_tx #(.CLOCK_HZ(1_000_000), .BAUD(100_000), .DEPTH(8)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Wr_i      (Wr_i),
    .WrAddr_i  (WrAddr_i),
    .WrData_i  (WrData_i),
    .Length_i  (Length_i),
    .Start_i   (Start_i),
`ifdef STREAM_TX_LOOP_EN
    .Stop_i    (Stop_i),
`endif
    .Busy_o    (Busy_o),
    .Done_o    (Done_o),
    .Pointer_o (Pointer_o),
    .Tx_o      (Tx_o)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    Wr_i = 1'b1;
    WrAddr_i = 3'(a);
    WrData_i = d;
    tick;
    Wr_i = 1'b0;
    model[a] = d;
  endtask

  task automatic add(input int len, input int n, input int cyc, input bit hold, input int wr_j, input int wr_a,
                     input int wr_d, input int pulse_j, input int stop_j, input int per);
    vec_t v;
    v = '{len, n, cyc, hold, wr_j, wr_a, wr_d, pulse_j, stop_j, per};
    tbl.push_back(v);
  endtask

  // Expected line level follows the frame rule: start 0, data LSB first, stop 1, P cycles each.
  task automatic burst(input int len, input int n, input int cyc, input bit hold, input int wr_j, input int wr_a,
                       input int wr_d, input int pulse_j, input int stop_j, input int per);
    logic [7:0] exp_b [16];
    logic [7:0] got [16];
    int werr, cerr, f, b;
    logic eb;
    werr = 0;
    cerr = 0;
    Length_i = 4'(len);
    Start_i = 1'b1;
    tick;
    chk("load", {26'd0, Busy_o, Done_o, Tx_o, Pointer_o}, {26'd0, 1'b1, 1'b0, 1'b1, 3'd0});
    Start_i = hold;
    Length_i = 4'($urandom);
    for (int j = 1; j <= cyc; j++) begin
      if ((j - 1) % FR == 0 && (j - 1) / FR < n) exp_b[(j - 1) / FR] = model[((j - 1) / FR) % per];
      Wr_i = j == wr_j;
      WrAddr_i = 3'(wr_a);
      WrData_i = 8'(wr_d);
      if (j == wr_j) model[wr_a] = 8'(wr_d);
      Start_i = hold || j == pulse_j;
`ifdef STREAM_TX_LOOP_EN
      Stop_i = j == stop_j;
`endif
      tick;
      Wr_i = 1'b0;
`ifdef STREAM_TX_LOOP_EN
      Stop_i = 1'b0;
`endif
      if (j < cyc) begin
        f = (j - 1) / FR;
        b = ((j - 1) / P) % 10;
        eb = b == 0 ? 1'b0 : b == 9 ? 1'b1 : exp_b[f][b-1];
        if (Tx_o !== eb) werr++;
        if ((j - 1) % P == P / 2 && b >= 1 && b <= 8) got[f][b-1] = Tx_o;
        if (Busy_o !== 1'b1 || Done_o !== 1'b0 || Pointer_o !== 3'(f % per)) cerr++;
      end
    end
    chk("done", {30'd0, Done_o, Busy_o}, 32'd2);
    chk("wave", werr, 0);
    chk("ctl", cerr, 0);
    for (int k = 0; k < n; k++) chk($sformatf("frame%0d", k), {24'd0, got[k]}, {24'd0, exp_b[k]});
    if (!hold) begin
      Start_i = 1'b0;
      tick;
      chk("idle", {29'd0, Busy_o, Done_o, Tx_o}, 32'd1);
    end
  endtask

  initial begin
    int dn, bs, len, n;
    compared = 0;
    mismatched = 0;
    Reset = 1'b1;
    Wr_i = 1'b0;
    Start_i = 1'b0;
    WrAddr_i = '0;
    WrData_i = '0;
    Length_i = '0;
`ifdef STREAM_TX_LOOP_EN
    Stop_i = 1'b0;
`endif
    repeat (3) tick;
    chk("reset", {26'd0, Tx_o, Busy_o, Done_o, Pointer_o}, {26'd0, 1'b1, 1'b0, 1'b0, 3'd0});
    Reset = 1'b0;
    tick;
    pat = '{8'h00, 8'h01, 8'h03, 8'h0F, 8'hFF, 8'hF0, 8'hC0, 8'h80};
    for (int i = 0; i < 8; i++) wr(i, pat[i]);
    add(0, 8, 801, 0, -1, 0, 0, -1, 1, 8);
    add(3, 3, 301, 0, -1, 0, 0, -1, 1, 3);
    add(9, 8, 801, 0, -1, 0, 0, -1, 1, 8);
    add(3, 3, 301, 1, -1, 0, 0, -1, 1, 3);
    add(2, 2, 201, 0, -1, 0, 0, 150, 1, 2);
    add(3, 3, 301, 0, 50, 2, 'hA5, -1, 1, 3);
    add(1, 1, 101, 0, 30, 0, 'h5A, -1, 1, 1);
    add(4, 4, 401, 0, 201, 2, 'h3C, -1, 1, 4);
    add(15, 8, 801, 0, -1, 0, 0, -1, 1, 8);
`ifdef STREAM_TX_LOOP_EN
    add(2, 6, 601, 0, -1, 0, 0, -1, 431, 2);
`endif
    foreach (tbl[i])
      burst(tbl[i].len, tbl[i].n, tbl[i].cyc, tbl[i].hold, tbl[i].wr_j, tbl[i].wr_a, tbl[i].wr_d,
            tbl[i].pulse_j, tbl[i].stop_j, tbl[i].per);
    wr(4, 8'h00);
    Length_i = '0;
    Start_i = 1'b1;
    tick;
    Start_i = 1'b0;
    for (int j = 1; j <= 4 * FR + 3 * P + 5; j++) begin
`ifdef STREAM_TX_LOOP_EN
      Stop_i = j == 1;
`endif
      tick;
    end
`ifdef STREAM_TX_LOOP_EN
    Stop_i = 1'b0;
`endif
    chk("pre_rst", {27'd0, Tx_o, Busy_o, Pointer_o}, {27'd0, 1'b0, 1'b1, 3'd4});
    #3 Reset = 1'b1;
    #1 chk("rst_async", {26'd0, Tx_o, Busy_o, Done_o, Pointer_o}, {26'd0, 1'b1, 1'b0, 1'b0, 3'd0});
    repeat (2) tick;
    Reset = 1'b0;
    dn = 0;
    bs = 0;
    repeat (FR) begin
      tick;
      dn += int'(Done_o);
      bs += int'(Busy_o);
    end
    chk("no_done", dn, 0);
    chk("no_busy", bs, 0);
    chk("post_rst", {26'd0, Tx_o, Busy_o, Done_o, Pointer_o}, {26'd0, 1'b1, 1'b0, 1'b0, 3'd0});
    burst(5, 5, 501, 0, -1, 0, 0, -1, 1, 5);
    for (int r = 0; r < 8; r++) begin
      repeat (3) wr($urandom_range(0, 7), 8'($urandom));
      len = $urandom_range(0, 15);
      n = (len == 0 || len > 8) ? 8 : len;
      burst(len, n, n * FR + 1, 0, $urandom_range(2, n * FR), $urandom_range(0, 7), $urandom_range(0, 255), -1, 1, n);
      repeat ($urandom_range(0, 3)) tick;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
